// File: rtl/exe_stage.sv
// Execute stage of the LoongArch32 5-stage pipeline: latches the decode bus, runs the ALU,
// issues one data-SRAM request per instruction and feeds forwarding/load-use info back to decode.
module exe_stage #(
    parameter int DS_ES_BUS_W = 151,
    parameter int ES_MS_BUS_W = 71,
    parameter int FWD_BUS_W   = 38
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ds_to_es_valid,
    input  logic [DS_ES_BUS_W-1:0] ds_es_bus,
    input  logic                   ms_allow_in,
    output logic                   es_allow_in,
    output logic                   es_to_ms_valid,
    output logic [ES_MS_BUS_W-1:0] es_ms_bus,
    output logic [FWD_BUS_W-1:0]   es_fwd_bus,
    output logic [4:0]             es_dest,
    output logic                   es_load,
    output logic                   data_sram_en,
    output logic [3:0]             data_sram_we,
    output logic [31:0]            data_sram_addr,
    output logic [31:0]            data_sram_wdata
);

    logic                   es_valid_q, es_valid_d;
    logic [DS_ES_BUS_W-1:0] payload_q, payload_d;

    logic [31:0] es_pc;
    logic [11:0] alu_op;
    logic        src1_is_pc, src2_is_imm, gr_we, mem_we, res_from_mem;
    logic [4:0]  dest;
    logic [31:0] imm, rj_value, rkd_value;
    logic        unused_src2_is_4;

    logic        es_ready_go;
    logic [31:0] src1, src2, alu_result;
    logic [4:0]  shamt;
    logic        mem_req;

    assign es_pc            = payload_q[150:119];
    assign alu_op           = payload_q[118:107];
    assign unused_src2_is_4 = payload_q[106];
    assign src1_is_pc       = payload_q[105];
    assign src2_is_imm      = payload_q[104];
    assign gr_we            = payload_q[103];
    assign mem_we           = payload_q[102];
    assign dest             = payload_q[101:97];
    assign imm              = payload_q[96:65];
    assign rj_value         = payload_q[64:33];
    assign rkd_value        = payload_q[32:1];
    assign res_from_mem     = payload_q[0];

    assign es_ready_go    = 1'b1;
    assign es_allow_in    = !es_valid_q || (es_ready_go && ms_allow_in);
    assign es_to_ms_valid = es_valid_q && es_ready_go;

    always_comb begin
        es_valid_d = es_valid_q;
        payload_d  = payload_q;
        if (es_allow_in) begin
            es_valid_d = ds_to_es_valid;
        end
        if (ds_to_es_valid && es_allow_in) begin
            payload_d = ds_es_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            payload_q  <= payload_d;
        end
    end

    assign src1  = src1_is_pc  ? es_pc : rj_value;
    assign src2  = src2_is_imm ? imm   : rkd_value;
    assign shamt = src2[4:0];

    // alu_op is one-hot, so OR-ing the gated results selects exactly one (or zero).
    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = alu_result | (src1 + src2);
        if (alu_op[1])  alu_result = alu_result | (src1 - src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> shamt);
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    // Request only when the instruction leaves for MEM, so a stalled store writes once.
    assign mem_req         = es_valid_q && ms_allow_in && (res_from_mem || mem_we);
    assign data_sram_en    = mem_req;
    assign data_sram_we    = {4{mem_req && mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    assign es_ms_bus  = {es_pc, res_from_mem, gr_we, dest, alu_result};
    assign es_fwd_bus = {es_valid_q && gr_we, dest, alu_result};
    assign es_dest    = (es_valid_q && gr_we) ? dest : 5'd0;
    assign es_load    = es_valid_q && res_from_mem;

endmodule
